// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, an iterative shift-add
// multiplier that stalls the front of the pipeline, and the EXE/MEM register.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwrite_exe,
  input  logic             memtoreg_exe,
  input  logic             memwrite_exe,
  input  logic             alusrc_exe,
  input  logic             regdst_exe,
  input  logic [3:0]       alucontrol_exe,
  input  logic [WIDTH-1:0] data1_exe,
  input  logic [WIDTH-1:0] data2_exe,
  input  logic [WIDTH-1:0] signext_exe,
  input  logic [4:0]       Rt_exe,
  input  logic [4:0]       Rd_exe,
  input  logic [4:0]       shamt_exe,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [WIDTH-1:0] aluout_fwd,
  input  logic [WIDTH-1:0] result_wb,
  output logic             stall_exe,
  output logic             regwrite_mem,
  output logic             memtoreg_mem,
  output logic             memwrite_mem,
  output logic [WIDTH-1:0] aluout_mem,
  output logic [WIDTH-1:0] writedata_mem,
  output logic [4:0]       writereg_mem,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             is_mul;

  assign is_mul    = (alucontrol_exe == OP_MUL);
  assign state_dbg = state;

  // Handshake with the hazard unit: stall_exe high means PC, IF/ID and ID/EXE
  // hold their contents; it rises combinationally in the cycle a MUL is seen
  // in IDLE, stays up through all BUSY cycles and drops in DONE, when the
  // product is written and the pipeline is released. Reset forces it low.
  assign stall_exe = rst && (((state == IDLE) && is_mul) || (state == BUSY));

  // Forwarding muxes for both operands, then the immediate select for srcB.
  always_comb begin
    src_a = data1_exe;
    fwd_b = data2_exe;
    case (forwardA)
      2'b01:   src_a = result_wb;
      2'b10:   src_a = aluout_fwd;
      default: src_a = data1_exe;
    endcase
    case (forwardB)
      2'b01:   fwd_b = result_wb;
      2'b10:   fwd_b = aluout_fwd;
      default: fwd_b = data2_exe;
    endcase
    src_b = alusrc_exe ? signext_exe : fwd_b;
  end

  // Single-cycle ALU; MUL is served by the iterative unit, so it yields 0 here.
  always_comb begin
    alu_result = '0;
    case (alucontrol_exe)
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_ADD:  alu_result = src_a + src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_NOR:  alu_result = ~(src_a | src_b);
      OP_SUB:  alu_result = src_a - src_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLL:  alu_result = src_b << shamt_exe;
      OP_SRL:  alu_result = src_b >> shamt_exe;
      OP_SRA:  alu_result = WIDTH'($signed(src_b) >>> shamt_exe);
      default: alu_result = '0;
    endcase
  end

  // Multiplier FSM: latch operands in IDLE, WIDTH shift-add steps in BUSY,
  // release in DONE. Operands are captured once so later forwarding changes
  // during the stall cannot disturb the product.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // EXE/MEM register: a fully zeroed bubble while stalled, the product in
  // DONE, otherwise the single-cycle ALU result.
  always_ff @(posedge clk) begin
    if (!rst || stall_exe) begin
      regwrite_mem  <= 1'b0;
      memtoreg_mem  <= 1'b0;
      memwrite_mem  <= 1'b0;
      aluout_mem    <= '0;
      writedata_mem <= '0;
      writereg_mem  <= '0;
    end else begin
      regwrite_mem  <= regwrite_exe;
      memtoreg_mem  <= memtoreg_exe;
      memwrite_mem  <= memwrite_exe;
      aluout_mem    <= (state == DONE) ? acc : alu_result;
      writedata_mem <= fwd_b;
      writereg_mem  <= regdst_exe ? Rd_exe : Rt_exe;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: instruction-level reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_exe_stage;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         regwrite_exe, memtoreg_exe, memwrite_exe, alusrc_exe, regdst_exe;
  logic [3:0]   alucontrol_exe;
  logic [W-1:0] data1_exe, data2_exe, signext_exe;
  logic [4:0]   Rt_exe, Rd_exe, shamt_exe;
  logic [1:0]   forwardA, forwardB;
  logic [W-1:0] aluout_fwd, result_wb;
  logic         stall_exe;
  logic         regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [W-1:0] aluout_mem, writedata_mem;
  logic [4:0]   writereg_mem;
  logic [1:0]   state_dbg;

  exe_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe),
    .memwrite_exe(memwrite_exe), .alusrc_exe(alusrc_exe), .regdst_exe(regdst_exe),
    .alucontrol_exe(alucontrol_exe),
    .data1_exe(data1_exe), .data2_exe(data2_exe), .signext_exe(signext_exe),
    .Rt_exe(Rt_exe), .Rd_exe(Rd_exe), .shamt_exe(shamt_exe),
    .forwardA(forwardA), .forwardB(forwardB),
    .aluout_fwd(aluout_fwd), .result_wb(result_wb),
    .stall_exe(stall_exe),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .writereg_mem(writereg_mem),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a MUL occupies W+1 stalled cycles, then one release cycle.
  int           mul_left  = 0;
  bit           done_pend = 0;
  logic [W-1:0] prod      = '0;
  bit           last_stall;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] d);
    if (sel == 2'b01) return result_wb;
    if (sel == 2'b10) return aluout_fwd;
    return d;
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    longint sa, sb;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = W'(longint'(a) + longint'(b));
      4'd3:  r = a ^ b;
      4'd4:  r = ~(a | b);
      4'd6:  r = W'(longint'(a) - longint'(b));
      4'd7:  r = (sa < sb) ? 1 : 0;
      4'd8:  r = W'(longint'(b) * (longint'(1) << sh));
      4'd9:  r = W'(longint'(b) / (longint'(1) << sh));
      4'd10: r = W'(sb >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock cycle: inputs already set (after a negedge). Checks stall now,
  // then the EXE/MEM outputs just after the rising edge.
  task automatic step();
    logic [W-1:0] a, fb, b;
    logic         e_stall, e_rw, e_mtr, e_mw;
    logic [W-1:0] e_alu, e_wd;
    logic [4:0]   e_wr;
    a  = pick(forwardA, data1_exe);
    fb = pick(forwardB, data2_exe);
    b  = alusrc_exe ? signext_exe : fb;
    if (rst && mul_left == 0 && !done_pend && alucontrol_exe == 4'b1100) begin
      mul_left = W + 1;
      prod     = W'(longint'(a) * longint'(b));
    end
    e_stall = rst && (mul_left > 0);
    #1;
    last_stall = stall_exe;
    check("stall_exe", W'(stall_exe), W'(e_stall));
    {e_rw, e_mtr, e_mw, e_alu, e_wd, e_wr} = '0;
    if (!rst) begin
      mul_left  = 0;
      done_pend = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) done_pend = 1;
    end else begin
      e_rw  = regwrite_exe;
      e_mtr = memtoreg_exe;
      e_mw  = memwrite_exe;
      e_wd  = fb;
      e_wr  = regdst_exe ? Rd_exe : Rt_exe;
      if (done_pend) begin
        e_alu     = prod;
        done_pend = 0;
      end else begin
        e_alu = alu_ref(alucontrol_exe, a, b, shamt_exe);
      end
    end
    @(posedge clk);
    #1;
    check("regwrite_mem",  W'(regwrite_mem), W'(e_rw));
    check("memtoreg_mem",  W'(memtoreg_mem), W'(e_mtr));
    check("memwrite_mem",  W'(memwrite_mem), W'(e_mw));
    check("aluout_mem",    aluout_mem,       e_alu);
    check("writedata_mem", writedata_mem,    e_wd);
    check("writereg_mem",  W'(writereg_mem), W'(e_wr));
    @(negedge clk);
  endtask

  // Driver helpers
  task automatic set_instr(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input logic [1:0] fa, input logic [1:0] fbs);
    rst = 1'b1;
    regwrite_exe = 1'b1; memtoreg_exe = 1'b0; memwrite_exe = 1'b0;
    alusrc_exe = 1'b0; regdst_exe = 1'b1;
    alucontrol_exe = op; data1_exe = d1; data2_exe = d2;
    signext_exe = '0; Rt_exe = 5'd9; Rd_exe = 5'd3; shamt_exe = 5'd0;
    forwardA = fa; forwardB = fbs;
  endtask

  task automatic shake_fwd();
    data1_exe  = $urandom; data2_exe = $urandom; signext_exe = $urandom;
    aluout_fwd = $urandom; result_wb = $urandom;
    forwardA   = 2'($urandom_range(0, 3)); forwardB = 2'($urandom_range(0, 3));
  endtask

  // Runs a full MUL with operand noise during the stall; returns stall count.
  task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y, output int cnt);
    set_instr(4'b1100, x, y, 2'b00, 2'b00);
    cnt = 0;
    for (int i = 0; i < W + 1; i++) begin
      step();
      if (last_stall) cnt++;
      shake_fwd();
    end
    step();
  endtask

  int cnt;
  logic [3:0] ops [16];

  initial begin
    for (int i = 0; i < 16; i++) ops[i] = 4'(i);
    set_instr(4'b0010, 32'd1, 32'd2, 2'b00, 2'b00);
    aluout_fwd = '0; result_wb = '0;
    @(negedge clk);

    // Reset
    rst = 1'b0;
    step();
    step();
    check("reset_aluout", aluout_mem, 32'd0);
    check("reset_state",  W'(state_dbg), 32'd0);

    // ADD 5+7 -> Rd 3
    set_instr(4'b0010, 32'd5, 32'd7, 2'b00, 2'b00);
    step();
    check("add_result",   aluout_mem, 32'd12);
    check("add_writereg", W'(writereg_mem), 32'd3);
    check("add_regwrite", W'(regwrite_mem), 32'd1);

    // SUB with forwarded srcA, then forwarded srcB
    set_instr(4'b0110, 32'd55, 32'd1, 2'b10, 2'b00);
    aluout_fwd = 32'd100;
    step();
    check("sub_fwdA", aluout_mem, 32'd99);
    forwardB = 2'b01; result_wb = 32'd4;
    step();
    check("sub_fwdB", aluout_mem, 32'd96);
    check("sub_wdata", writedata_mem, 32'd4);

    // SLT signed and SRA
    set_instr(4'b0111, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00);
    step();
    check("slt_signed", aluout_mem, 32'd1);
    set_instr(4'b1010, 32'd0, 32'h8000_0000, 2'b00, 2'b00);
    shamt_exe = 5'd4;
    step();
    check("sra", aluout_mem, 32'hF800_0000);

    // MUL 6*7
    run_mul(32'd6, 32'd7, cnt);
    check("mul_stall_cycles", W'(cnt), 32'd33);
    check("mul_result",   aluout_mem, 32'd42);
    check("mul_regwrite", W'(regwrite_mem), 32'd1);
    check("mul_released", W'(last_stall), 32'd0);

    // MUL wrap
    run_mul(32'hFFFF_FFFF, 32'd2, cnt);
    check("mul_wrap", aluout_mem, 32'hFFFF_FFFE);

    // Reset at BUSY cycle 10
    set_instr(4'b1100, 32'd6, 32'd7, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    step();
    check("abort_stall",  W'(last_stall), 32'd0);
    check("abort_aluout", aluout_mem, 32'd0);
    check("abort_state",  W'(state_dbg), 32'd0);
    set_instr(4'b0010, 32'd1, 32'd2, 2'b00, 2'b00);
    step();
    check("abort_no_mul", aluout_mem, 32'd3);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (mul_left > 0 || done_pend) begin
        shake_fwd();
      end else begin
        regwrite_exe = 1'($urandom); memtoreg_exe = 1'($urandom);
        memwrite_exe = 1'($urandom); alusrc_exe = 1'($urandom);
        regdst_exe = 1'($urandom);
        alucontrol_exe = ($urandom_range(0, 15) == 0) ? 4'b1100 : ops[$urandom_range(0, 15)];
        Rt_exe = 5'($urandom); Rd_exe = 5'($urandom); shamt_exe = 5'($urandom);
        shake_fwd();
      end
      rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
